cs_stream_src: RTL and testbench
================================

CS_STREAM_SRC -- requirements
Module: cs_stream_src

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: sample FIFO entries, power of 2.
REQ-002 Parameter WIN, default 9: CS window length; minimum frame length.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin a frame.
REQ-007 frame_len  input  8  samples in the frame; latched on accepted start.
REQ-008 in_valid  input  1  producer sample valid.
REQ-009 in_data  input  8  producer sample.
REQ-010 in_ready  output  1  FIFO can accept a sample.
REQ-011 X  output  8  sample stream to the CS block; one sample per cycle in STREAM.
REQ-012 cs_rst  output  1  reset pulse to the CS block.
REQ-013 Y  input  10  CS result; settles within the cycle its sample is driven.
REQ-014 y_valid  output  1  y_data holds a full-window result.
REQ-015 y_data  output  10  registered CS result.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  single-cycle end-of-frame pulse.
REQ-018 underrun  output  1  sticky underrun flag, cleared by the next accepted start.

Function
REQ-019 FSM states: IDLE, CLEAR, PRIME, STREAM, DONE.
REQ-020 IDLE->CLEAR on start with frame_len>=WIN; start with frame_len<WIN is ignored; start outside IDLE is ignored.
REQ-021 CLEAR lasts exactly 1 cycle: cs_rst=1, X=0; then PRIME.
REQ-022 PRIME: X=0, no FIFO pops; ->STREAM when FIFO count >= WIN.
REQ-023 STREAM: each cycle pops one FIFO entry onto X (registered, so X carries that sample the following cycle); sample counter increments per driven cycle; ->DONE after frame_len samples are driven.
REQ-024 Underrun: FIFO empty in STREAM -> X repeats the previous sample, the repeat counts as a frame sample, underrun set to 1.
REQ-025 DONE lasts 1 cycle with done=1; then IDLE. X returns to 0 in IDLE.
REQ-026 FIFO: in_ready = !full in all states; push when in_valid&&in_ready; simultaneous push and pop when full or empty is legal and the count is unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-027 Samples left in the FIFO after DONE are retained for the next frame.
REQ-028 Y capture: when sample k (1-based) is on X during cycle t, Y is registered into y_data at the edge ending cycle t; y_valid=1 in cycle t+1 iff WIN<=k<=frame_len.
REQ-029 A frame yields exactly frame_len-WIN+1 y_valid pulses; the last pulse coincides with done.
REQ-030 y_data holds its value when y_valid=0.

Reset
REQ-031 On reset: state=IDLE, FIFO empty, counters 0, X=0, cs_rst=0, y_valid=0, y_data=0, done=0, underrun=0, busy=0.
REQ-032 A reset asserted mid-frame aborts the frame without a done pulse, discards FIFO contents, and drives no y_valid in the cycle after reset.

Verification
REQ-033 Push 9 samples of 10, start with frame_len=9 -> one cs_rst pulse, 9 samples of X=10, one y_valid with y_data=22 (sum 90, approx 10), coincident with done.
REQ-034 Push samples 1..12, frame_len=12 -> 4 y_valid pulses; first y_data=11 (window 1..9: sum 45, avg 5, approx 5); last pulse coincides with done; underrun=0.
REQ-035 Push 9 samples, frame_len=10 -> 10th X repeats the 9th sample, underrun=1, 2 y_valid pulses, done asserted.
REQ-036 start with frame_len=5 -> stays IDLE, busy=0, no cs_rst; producer pushes 17 samples -> in_ready=0 after 16 accepted.
REQ-037 reset asserted at the 5th STREAM cycle of a 12-sample frame -> next cycle all outputs at reset values; a new frame then runs cleanly from an empty FIFO.

Source files
------------

// File: rtl/cs_stream_src.sv
// Streams buffered producer samples into an external CS block, one per cycle,
// and registers the full-window results the CS block returns.
module cs_stream_src #(
  parameter int FIFO_DEPTH = 16,
  parameter int WIN        = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] X,
  output logic       cs_rst,
  input  logic [9:0] Y,
  output logic       y_valid,
  output logic [9:0] y_data,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   WIN_CNT  = (AW+1)'(WIN);
  localparam logic [7:0]    WIN8     = 8'(WIN);

  typedef enum logic [2:0] {IDLE, CLEAR, PRIME, STREAM, DONE} state_t;

  state_t        state, state_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [7:0]    len_q;
  logic [7:0]    sent;
  logic          full, empty, push, push_eff, want, pop, bypass, start_ok, win_full;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign start_ok  = (state == IDLE) && start && (frame_len >= WIN8);
  // 'sent' is also the index of the sample currently on X
  assign want      = (state == STREAM) && (sent != len_q);
  assign pop       = want && !empty;
  // An empty FIFO with a sample arriving hands it straight to X
  assign bypass    = want && empty && push;
  assign push_eff  = push && !bypass;
  assign win_full  = (state == STREAM) && (sent >= WIN8);

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign cs_rst = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = CLEAR;
      CLEAR:   state_next = PRIME;
      PRIME:   if (count >= WIN_CNT) state_next = STREAM;
      STREAM:  if (sent == len_q) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      len_q    <= '0;
      sent     <= '0;
      X        <= '0;
      y_valid  <= 1'b0;
      y_data   <= '0;
      underrun <= 1'b0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({push_eff, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (start_ok) begin
        len_q    <= frame_len;
        underrun <= 1'b0;
      end

      if (state == CLEAR) sent <= '0;
      else if (want)      sent <= sent + 1'b1;

      // A starved stream repeats the last sample and still counts it
      if (pop)         X <= mem[rd_ptr];
      else if (bypass) X <= in_data;
      else if (want) begin
        X        <= X;
        underrun <= 1'b1;
      end else         X <= '0;

      y_valid <= win_full;
      if (win_full) y_data <= Y;
    end
  end

endmodule

// File: tb/tb_cs_stream_src.sv
// Bench for cs_stream_src: a summing CS stand-in, a queue-based frame model
// checked every cycle, directed scenarios pinned with literals, then random traffic.
module tb_cs_stream_src;

  localparam int DEPTH = 16;
  localparam int WIN   = 9;
  localparam int P_IDLE = 0, P_CLEAR = 1, P_PRIME = 2, P_STREAM = 3, P_DONE = 4;

  logic       clk = 1'b0;
  logic       reset, start, in_valid, in_ready, cs_rst, y_valid, busy, done, underrun;
  logic [7:0] frame_len, in_data, X;
  logic [9:0] Y, y_data;

  int n_cmp  = 0;
  int n_fail = 0;
  bit checking = 0;

  always #5 clk = ~clk;

  cs_stream_src #(.FIFO_DEPTH(DEPTH), .WIN(WIN)) dut (
    .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .X(X), .cs_rst(cs_rst), .Y(Y), .y_valid(y_valid), .y_data(y_data),
    .busy(busy), .done(done), .underrun(underrun)
  );

  // CS stand-in: quarter of the sum of the current X and the previous WIN-1 X values
  logic [7:0] cs_hist [WIN-1];
  int         cs_sum;
  always @* begin
    cs_sum = int'(X);
    for (int i = 0; i < WIN-1; i++) cs_sum += int'(cs_hist[i]);
    Y = 10'(cs_sum >> 2);
  end
  always @(posedge clk) begin
    if (reset || cs_rst) begin
      for (int i = 0; i < WIN-1; i++) cs_hist[i] <= '0;
    end else begin
      for (int i = WIN-2; i > 0; i--) cs_hist[i] <= cs_hist[i-1];
      cs_hist[0] <= X;
    end
  end

  // Reference model: phase, FIFO queue and the list of samples shown in this frame
  int         ph = P_IDLE;
  int         m_len = 0;
  bit [7:0]   q[$];
  bit [7:0]   frame[$];
  logic [7:0] e_x = '0;
  logic       e_yv = 1'b0, e_und = 1'b0;
  logic [9:0] e_y = '0;

  function automatic logic [9:0] win_avg(int k);
    int s = 0;
    for (int i = k - WIN; i < k; i++) s += int'(frame[i]);
    return 10'(s >> 2);
  endfunction

  task automatic model_step();
    bit       do_push;
    bit [7:0] smp;
    int       k;
    if (reset) begin
      q.delete();
      frame.delete();
      ph = P_IDLE; m_len = 0;
      e_x = '0; e_yv = 1'b0; e_y = '0; e_und = 1'b0;
      return;
    end
    do_push = in_valid && (q.size() < DEPTH);
    e_x  = '0;
    e_yv = 1'b0;
    case (ph)
      P_IDLE: if (start && frame_len >= 8'(WIN)) begin
        ph = P_CLEAR; m_len = int'(frame_len); e_und = 1'b0; frame.delete();
      end
      P_CLEAR: ph = P_PRIME;
      P_PRIME: if (q.size() >= WIN) ph = P_STREAM;
      P_STREAM: begin
        k = frame.size();
        if (k >= WIN) begin
          e_yv = 1'b1;
          e_y  = win_avg(k);
        end
        if (k == m_len) ph = P_DONE;
        else begin
          if (do_push) begin
            q.push_back(in_data);
            do_push = 0;
          end
          if (q.size() > 0) smp = q.pop_front();
          else begin
            smp   = (k > 0) ? frame[k-1] : 8'd0;
            e_und = 1'b1;
          end
          frame.push_back(smp);
          e_x = smp;
        end
      end
      P_DONE: ph = P_IDLE;
      default: ph = P_IDLE;
    endcase
    if (do_push) q.push_back(in_data);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (checking) begin
      checkOutput("X",        32'(X),        32'(e_x));
      checkOutput("y_valid",  32'(y_valid),  32'(e_yv));
      checkOutput("y_data",   32'(y_data),   32'(e_y));
      checkOutput("underrun", 32'(underrun), 32'(e_und));
      checkOutput("busy",     32'(busy),     32'(ph != P_IDLE));
      checkOutput("done",     32'(done),     32'(ph == P_DONE));
      checkOutput("cs_rst",   32'(cs_rst),   32'(ph == P_CLEAR));
      checkOutput("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    end
  end

  // Per-scenario statistics taken from the DUT, compared against hand-worked literals
  int         st_yv = 0, st_csrst = 0, st_watch = 0;
  logic [9:0] st_first = '0, st_last = '0;
  logic       st_lastdone = 1'b0;
  logic [7:0] watch_x = '0;

  initial forever begin
    @(negedge clk);
    if (y_valid === 1'b1) begin
      st_yv++;
      if (st_yv == 1) st_first = y_data;
      st_last     = y_data;
      st_lastdone = done;
    end
    if (cs_rst === 1'b1) st_csrst++;
    if (busy === 1'b1 && X === watch_x) st_watch++;
  end

  task automatic clearStats(input logic [7:0] wx);
    st_yv = 0; st_csrst = 0; st_watch = 0;
    st_first = '0; st_last = '0; st_lastdone = 1'b0;
    watch_x = wx;
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] len, input logic v, input logic [7:0] d);
    @(negedge clk);
    start = s; frame_len = len; in_valid = v; in_data = d;
  endtask

  task automatic pushSeq(input int n, input int base, input int step);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'd0, 1'b1, 8'(base + i*step));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  task automatic waitDone(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
      if (done === 1'b1) seen = 1;
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL done_timeout: got no done, expected done within %0d cycles", budget);
    end
    idleCycles(2);
  endtask

  initial begin
    int acc;
    bit hit;
    reset = 1'b1; start = 1'b0; frame_len = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    checking = 1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_X",    32'(X),    32'd0);
    checkOutput("reset_yd",   32'(y_data), 32'd0);
    reset = 1'b0;

    $display("[TB] nine samples of 10, frame_len 9");
    clearStats(8'd10);
    pushSeq(9, 10, 0);
    applyStimulus(1'b1, 8'd9, 1'b0, 8'd0);
    waitDone(60);
    checkOutput("t1_cs_rst_pulses", 32'(st_csrst), 32'd1);
    checkOutput("t1_x10_cycles",    32'(st_watch), 32'd9);
    checkOutput("t1_yv_pulses",     32'(st_yv),    32'd1);
    checkOutput("t1_y_data",        32'(st_first), 32'd22);
    checkOutput("t1_last_with_done",32'(st_lastdone), 32'd1);

    $display("[TB] samples 1..12, frame_len 12");
    clearStats(8'd200);
    pushSeq(12, 1, 1);
    applyStimulus(1'b1, 8'd12, 1'b0, 8'd0);
    waitDone(60);
    checkOutput("t2_yv_pulses",     32'(st_yv),    32'd4);
    checkOutput("t2_first_y",       32'(st_first), 32'd11);
    checkOutput("t2_last_y",        32'(st_last),  32'd18);
    checkOutput("t2_last_with_done",32'(st_lastdone), 32'd1);
    checkOutput("t2_underrun",      32'(underrun), 32'd0);

    $display("[TB] samples 1..9, frame_len 10 (starved)");
    clearStats(8'd9);
    pushSeq(9, 1, 1);
    applyStimulus(1'b1, 8'd10, 1'b0, 8'd0);
    waitDone(60);
    checkOutput("t3_x9_cycles",     32'(st_watch), 32'd2);
    checkOutput("t3_underrun",      32'(underrun), 32'd1);
    checkOutput("t3_yv_pulses",     32'(st_yv),    32'd2);
    checkOutput("t3_first_y",       32'(st_first), 32'd11);
    checkOutput("t3_last_y",        32'(st_last),  32'd13);
    checkOutput("t3_last_with_done",32'(st_lastdone), 32'd1);

    $display("[TB] short start ignored, FIFO fill to full");
    clearStats(8'd250);
    applyStimulus(1'b1, 8'd5, 1'b0, 8'd0);
    idleCycles(2);
    checkOutput("t4_busy",     32'(busy),     32'd0);
    checkOutput("t4_cs_rst",   32'(st_csrst), 32'd0);
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b1, 8'(100 + i));
      if (in_ready === 1'b1) acc++;
    end
    idleCycles(1);
    checkOutput("t4_accepted", 32'(acc),      32'd16);
    checkOutput("t4_in_ready", 32'(in_ready), 32'd0);

    $display("[TB] reset in the fifth STREAM cycle of a 12-sample frame");
    applyStimulus(1'b1, 8'd12, 1'b0, 8'd0);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
      if (ph == P_STREAM && frame.size() == 4) hit = 1;
    end
    if (!hit) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL t5_reach_stream: got no fifth STREAM cycle, expected one within 40 cycles");
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("t5_busy",     32'(busy),     32'd0);
    checkOutput("t5_y_valid",  32'(y_valid),  32'd0);
    checkOutput("t5_done",     32'(done),     32'd0);
    checkOutput("t5_X",        32'(X),        32'd0);
    checkOutput("t5_in_ready", 32'(in_ready), 32'd1);
    clearStats(8'd250);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 8'd0, 1'b1, 8'($urandom_range(0, 255)));
    applyStimulus(1'b1, 8'd9, 1'b0, 8'd0);
    waitDone(60);
    checkOutput("t5_yv_pulses", 32'(st_yv), 32'd1);

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom_range(0, 5) == 0), 8'($urandom_range(0, 24)),
                    ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
      reset = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0;
    idleCycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
